phy_tx_sched: RTL

- Transmit-side scheduler that shares the single 8-bit PHY transmit path (COM/valid insertion stage, then serializer) among NUM_REQ byte-stream requesters.
- After reset, sequences a link-alignment phase of COM symbols.
- Then grants the path round-robin in bounded bursts and presents one registered byte stream with a valid flag to the COM/valid stage.
- Runs on the byte clock cclk.

---
 rtl/phy_tx_pkg.sv | 13 +
 rtl/phy_tx_sched_rr_pick.sv | 28 ++
 rtl/phy_tx_sched.sv | 133 +++++++++++++
 3 files changed

// File: rtl/phy_tx_pkg.sv
// Shared definitions for the PHY transmit scheduler: the default alignment symbol
// and the scheduler state encoding.
package phy_tx_pkg;

  localparam logic [7:0] COM_SYM_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    ARB   = 2'd1,
    SEND  = 2'd2
  } state_t;

endpackage

// File: rtl/phy_tx_sched_rr_pick.sv
// Round-robin picker: finds the first asserted req scanning upward from ptr+1 with wrap.
// Purely combinational so the receive side can reuse it.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               any_req
);

  logic found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
        pick[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/phy_tx_sched.sv
// Shares the 8-bit PHY transmit path among NUM_REQ requesters: COM alignment after reset,
// then round-robin bounded bursts. Define PHY_TX_SCHED_STATS_EN to build the byte counter.
//
// state | meaning
// ALIGN | sending COM_SYM for ALIGN_COUNT cycles, requests ignored
// ARB   | one idle cycle, choose next owner round-robin
// SEND  | forwarding bytes from the granted requester
module phy_tx_sched
  import phy_tx_pkg::*;
#(
  parameter int          NUM_REQ     = 4,
  parameter int          BURST_MAX   = 4,
  parameter int          ALIGN_COUNT = 4,
  parameter logic [7:0]  COM_SYM     = COM_SYM_DEFAULT
) (
  input  logic                   cclk,
  input  logic                   default_values,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   data_in,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             data_out,
  output logic                   valid_out,
  output logic                   aligned,
  output logic [15:0]            byte_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [7:0]         align_cnt;
  logic [3:0]         burst_cnt;
  logic [PTR_W-1:0]   ptr;
  logic [NUM_REQ-1:0] pick;
  logic               pick_any;
  logic [PTR_W-1:0]   owner_idx;
  logic               owner_req;
  logic [7:0]         owner_byte;

  rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr_pick (
    .req     (req),
    .ptr     (ptr),
    .pick    (pick),
    .any_req (pick_any)
  );

  always_comb begin
    owner_idx  = '0;
    owner_req  = 1'b0;
    owner_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        owner_idx  = PTR_W'(i);
        owner_req  = req[i];
        owner_byte = data_in[8*i +: 8];
      end
    end
  end

  // grant is one-hot in SEND, so this can never raise more than one ack bit
  assign ack = (state == SEND) ? (grant & req) : '0;

  always_ff @(posedge cclk or negedge default_values) begin
    if (!default_values) begin
      state     <= ALIGN;
      align_cnt <= '0;
      burst_cnt <= '0;
      ptr       <= PTR_W'(NUM_REQ - 1);
      grant     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      aligned   <= 1'b0;
    end else begin
      case (state)
        ALIGN: begin
          if (align_cnt == 8'(ALIGN_COUNT)) begin
            aligned  <= 1'b1;
            data_out <= '0;
            state    <= ARB;
          end else begin
            data_out  <= COM_SYM;
            align_cnt <= align_cnt + 8'd1;
          end
        end
        ARB: begin
          valid_out <= 1'b0;
          data_out  <= '0;
          if (pick_any) begin
            grant     <= pick;
            burst_cnt <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (owner_req) begin
            data_out  <= owner_byte;
            valid_out <= 1'b1;
            burst_cnt <= burst_cnt + 4'd1;
            if (burst_cnt == 4'(BURST_MAX - 1)) begin
              grant <= '0;
              ptr   <= owner_idx;
              state <= ARB;
            end
          end else begin
            data_out  <= '0;
            valid_out <= 1'b0;
            grant     <= '0;
            ptr       <= owner_idx;
            state     <= ARB;
          end
        end
        default: state <= ALIGN;
      endcase
    end
  end

`ifdef PHY_TX_SCHED_STATS_EN
  logic [15:0] byte_cnt_q;

  always_ff @(posedge cclk or negedge default_values) begin
    if (!default_values) begin
      byte_cnt_q <= '0;
    end else if (state == SEND && owner_req && byte_cnt_q != 16'hFFFF) begin
      byte_cnt_q <= byte_cnt_q + 16'd1;
    end
  end

  assign byte_count = byte_cnt_q;
`else
  assign byte_count = '0;
`endif

endmodule
